// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared bridge types and constants for the request arbiter
package bridge_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } bridge_arb_state_e;

    localparam int          BRIDGE_WORD_W       = 16;
    localparam logic [15:0] BRIDGE_RESP_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/bridge_req_arbiter_if.sv
// rtl/bridge_req_arbiter_if.sv - requester-side and driver-side signals of bridge_req_arbiter
interface bridge_req_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       rq_valid;
    logic [N_REQ-1:0][15:0] rq_word;
    logic [N_REQ-1:0]       rq_ready;
    logic [N_REQ-1:0]       rq_done;
    logic [15:0]            rq_result;
    logic                   rq_error;
    logic                   drv_valid;
    logic [15:0]            drv_word;
    logic                   drv_ready;
    logic                   drv_resp_valid;
    logic [15:0]            drv_resp_word;

    modport slave (
        input  rq_valid, rq_word, drv_ready, drv_resp_valid, drv_resp_word,
        output rq_ready, rq_done, rq_result, rq_error, drv_valid, drv_word
    );

    modport master (
        output rq_valid, rq_word, drv_ready, drv_resp_valid, drv_resp_word,
        input  rq_ready, rq_done, rq_result, rq_error, drv_valid, drv_word
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant: first request at or above ptr, modulo N
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/bridge_req_arbiter.sv
// rtl/bridge_req_arbiter.sv - round-robin sharing of the bridge_driver request channel, one transaction in flight
// Optional response timeout enabled by BRIDGE_REQ_TIMEOUT_EN.
module bridge_req_arbiter
    import bridge_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                 clk,
    input  logic                 reset,
    bridge_req_arbiter_if.slave  bus,
    output logic                 busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    bridge_arb_state_e state, state_next;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [15:0]       cmd_reg;
    logic [15:0]       result_reg;
    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     grant_idx;
    logic              any;
    logic              timeout;

    rr_arbiter #(.N(N_REQ), .IW(PW)) u_rr (
        .req       (bus.rq_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

`ifdef BRIDGE_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic          err_reg;

    // Held at zero through ISSUE so the first WAIT cycle sees timer == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state == ARB_ISSUE)
                timer <= '0;
            else if (state == ARB_WAIT)
                timer <= timer + 1'b1;
            if (state == ARB_WAIT)
                err_reg <= !bus.drv_resp_valid;
        end
    end

    assign timeout      = (state == ARB_WAIT) && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign bus.rq_error = err_reg && (state == ARB_DONE);
`else
    assign timeout      = 1'b0;
    assign bus.rq_error = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        bus.rq_ready  = '0;
        bus.rq_done   = '0;
        bus.drv_valid = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any) begin
                    bus.rq_ready = grant;
                    state_next   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.drv_valid = 1'b1;
                if (bus.drv_ready)
                    state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus.drv_resp_valid || timeout)
                    state_next = ARB_DONE;
            end
            ARB_DONE: begin
                bus.rq_done[owner] = 1'b1;
                state_next         = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            cmd_reg    <= '0;
            result_reg <= '0;
        end else begin
            state <= state_next;
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        cmd_reg <= bus.rq_word[grant_idx];
                        owner   <= grant_idx;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.drv_ready)
                        rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                ARB_WAIT: begin
                    // A response on the timeout cycle takes precedence.
                    if (bus.drv_resp_valid)
                        result_reg <= bus.drv_resp_word;
                    else if (timeout)
                        result_reg <= BRIDGE_RESP_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    assign bus.drv_word  = cmd_reg;
    assign bus.rq_result = result_reg;
    assign busy          = (state != ARB_IDLE);
endmodule

// File: tb/tb_bridge_req_arbiter.sv
// tb/tb_bridge_req_arbiter.sv - scoreboard bench for bridge_req_arbiter (timeout cases with BRIDGE_REQ_TIMEOUT_EN)
module tb_bridge_req_arbiter;
    localparam int N     = 4;
    localparam int TB_TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    bridge_req_arbiter_if #(.N_REQ(N)) bus ();

    bridge_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    typedef struct {
        int          owner;
        logic [15:0] result;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ptr  = 0;

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_ptr = 0;
    endtask

    // Runs one full transaction from an IDLE cycle whose rq_valid is already driven.
    task automatic serve_one(input int rdy_dly, input int rsp_dly, input logic [15:0] rsp,
                             input bit drop, input logic [N-1:0] raise, input bit stray,
                             output int g);
        logic [15:0]  w;
        logic [N-1:0] oh;
        exp_t         e;
        #1;
        g  = model_grant(bus.rq_valid);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        n_checks++;
        if (g < 0 || bus.rq_ready !== oh) begin
            n_fail++;
            $display("FAIL grant: rq_ready=%b required %b", bus.rq_ready, oh);
        end
        if (g < 0) return;
        w = bus.rq_word[g];
        tick();
        if (drop) bus.rq_valid[g] = 1'b0;
        bus.rq_valid = bus.rq_valid | raise;
        n_checks++;
        if (bus.drv_valid !== 1'b1 || bus.drv_word !== w || bus.rq_ready !== '0) begin
            n_fail++;
            $display("FAIL issue: drv_valid=%b drv_word=%h rq_ready=%b required 1 %h 0",
                     bus.drv_valid, bus.drv_word, bus.rq_ready, w);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            if (stray && i == 0) begin
                bus.drv_resp_valid = 1'b1;
                bus.drv_resp_word  = 16'hDEAD;
            end
            tick();
            bus.drv_resp_valid = 1'b0;
            n_checks++;
            if (bus.drv_valid !== 1'b1 || bus.drv_word !== w || bus.rq_done !== '0) begin
                n_fail++;
                $display("FAIL hold: drv_valid=%b drv_word=%h rq_done=%b required 1 %h 0",
                         bus.drv_valid, bus.drv_word, bus.rq_done, w);
            end
        end
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        exp_ptr = (g + 1) % N;
        n_checks++;
        if (bus.drv_valid !== 1'b0 || busy !== 1'b1 || bus.rq_ready !== '0) begin
            n_fail++;
            $display("FAIL wait_entry: drv_valid=%b busy=%b rq_ready=%b required 0 1 0",
                     bus.drv_valid, busy, bus.rq_ready);
        end
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            n_checks++;
            if (bus.rq_done !== '0 || bus.rq_ready !== '0) begin
                n_fail++;
                $display("FAIL wait: rq_done=%b rq_ready=%b required 0 0", bus.rq_done, bus.rq_ready);
            end
        end
        bus.drv_resp_valid = 1'b1;
        bus.drv_resp_word  = rsp;
        e = '{owner: g, result: rsp, err: 1'b0};
        sb.push_back(e);
        tick();
        bus.drv_resp_valid = 1'b0;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL done: scoreboard empty, rq_done=%b required a queued entry", bus.rq_done);
        end else begin
            e  = sb.pop_front();
            oh = '0;
            oh[e.owner] = 1'b1;
            if (bus.rq_done !== oh || bus.rq_result !== e.result || bus.rq_error !== e.err) begin
                n_fail++;
                $display("FAIL done: rq_done=%b result=%h error=%b required %b %h %b",
                         bus.rq_done, bus.rq_result, bus.rq_error, oh, e.result, e.err);
            end
        end
        tick();
        n_checks++;
        if (bus.rq_done !== '0 || busy !== 1'b0 || bus.rq_result !== rsp) begin
            n_fail++;
            $display("FAIL after_done: rq_done=%b busy=%b result=%h required 0 0 %h",
                     bus.rq_done, busy, bus.rq_result, rsp);
        end
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus.rq_valid       = '0;
        bus.drv_ready      = 1'b0;
        bus.drv_resp_valid = 1'b0;
        bus.drv_resp_word  = '0;
        for (int i = 0; i < N; i++) bus.rq_word[i] = 16'hA000 + 16'(i);
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || bus.drv_valid !== 1'b0 || bus.drv_word !== 16'h0 || bus.rq_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b drv_valid=%b drv_word=%h rq_ready=%b required all 0",
                     busy, bus.drv_valid, bus.drv_word, bus.rq_ready);
        end
        n_checks++;
        if (bus.rq_done !== '0 || bus.rq_result !== 16'h0 || bus.rq_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: rq_done=%b result=%h error=%b required all 0",
                     bus.rq_done, bus.rq_result, bus.rq_error);
        end
        reset   = 1'b0;
        exp_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        int g;
        bus.rq_word[2] = 16'h0140;
        bus.rq_valid   = 4'b0100;
        serve_one(3, 2, 16'h0001, 1'b1, '0, 1'b0, g);
        n_checks++;
        if (g !== 2) begin
            n_fail++;
            $display("FAIL single_owner: granted %0d required 2", g);
        end
    endtask

    task automatic test_round_robin();
        int g;
        int order[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < N; i++) bus.rq_word[i] = 16'hA000 + 16'(i);
        bus.rq_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            serve_one(0, 0, 16'h1000 + 16'(k), 1'b0, '0, 1'b0, g);
            n_checks++;
            if (g !== order[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: granted %0d required %0d", k, g, order[k]);
            end
        end
        bus.rq_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back_block();
        int g;
        bus.rq_valid = 4'b1000;
        serve_one(1, 3, 16'h3333, 1'b1, 4'b0010, 1'b0, g);
        n_checks++;
        if (g !== 3) begin
            n_fail++;
            $display("FAIL block_first: granted %0d required 3", g);
        end
        serve_one(0, 0, 16'h1111, 1'b1, '0, 1'b0, g);
        n_checks++;
        if (g !== 1) begin
            n_fail++;
            $display("FAIL block_second: granted %0d required 1", g);
        end
    endtask

    task automatic test_reset_in_wait();
        int g;
        bus.rq_valid = 4'b0001;
        #1;
        n_checks++;
        if (bus.rq_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_wait_grant: rq_ready=%b required 0001", bus.rq_ready);
        end
        tick();
        bus.rq_valid  = '0;
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_busy: busy=%b required 1", busy);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b0 || bus.drv_valid !== 1'b0 || bus.rq_done !== '0) begin
                n_fail++;
                $display("FAIL rst_wait_after[%0d]: busy=%b drv_valid=%b rq_done=%b required 0 0 0",
                         i, busy, bus.drv_valid, bus.rq_done);
            end
            tick();
        end
        bus.rq_valid = 4'b0100;
        serve_one(0, 1, 16'h0BEE, 1'b1, '0, 1'b0, g);
        n_checks++;
        if (g !== 2) begin
            n_fail++;
            $display("FAIL rst_wait_resume: granted %0d required 2", g);
        end
    endtask

    task automatic test_stray_response();
        int g;
        bus.rq_valid       = '0;
        bus.drv_resp_valid = 1'b1;
        bus.drv_resp_word  = 16'h5555;
        tick();
        bus.drv_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.rq_done !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_idle[%0d]: rq_done=%b busy=%b required 0 0", i, bus.rq_done, busy);
            end
            tick();
        end
        bus.rq_valid = 4'b0010;
        serve_one(2, 0, 16'h7777, 1'b1, '0, 1'b1, g);
        n_checks++;
        if (g !== 1) begin
            n_fail++;
            $display("FAIL stray_owner: granted %0d required 1", g);
        end
    endtask

`ifdef BRIDGE_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int           cnt;
        int           g;
        exp_t         e;
        logic [N-1:0] oh;
        for (int pass = 0; pass < 2; pass++) begin
            bus.rq_valid = 4'b0001;
            #1;
            g = model_grant(bus.rq_valid);
            tick();
            bus.rq_valid  = '0;
            bus.drv_ready = 1'b1;
            tick();
            bus.drv_ready = 1'b0;
            exp_ptr = (g + 1) % N;
            cnt = 0;
            if (pass == 0) begin
                e = '{owner: g, result: 16'hFFFF, err: 1'b1};
                sb.push_back(e);
                while (bus.rq_done === '0 && cnt < 40) begin
                    tick();
                    cnt++;
                end
            end else begin
                for (int i = 0; i < TB_TO - 1; i++) begin
                    tick();
                    cnt++;
                end
                bus.drv_resp_valid = 1'b1;
                bus.drv_resp_word  = 16'h1234;
                e = '{owner: g, result: 16'h1234, err: 1'b0};
                sb.push_back(e);
                tick();
                cnt++;
                bus.drv_resp_valid = 1'b0;
            end
            e  = sb.pop_front();
            oh = '0;
            oh[e.owner] = 1'b1;
            n_checks++;
            if (cnt !== TB_TO || bus.rq_done !== oh || bus.rq_result !== e.result || bus.rq_error !== e.err) begin
                n_fail++;
                $display("FAIL timeout[%0d]: cycles=%0d rq_done=%b result=%h error=%b required %0d %b %h %b",
                         pass, cnt, bus.rq_done, bus.rq_result, bus.rq_error, TB_TO, oh, e.result, e.err);
            end
            tick();
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_block();
        test_reset_in_wait();
        test_stray_response();
`ifdef BRIDGE_REQ_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
